digital_tube_scan: RTL
======================

// Module: digital_tube_scan
// PURPOSE
//   Parametrised multiplexed 7-segment scanner for N-digit common-anode/cathode tubes.
//   Time-multiplexes DIGITS hex nibbles with per-digit decimal points and global 16-level PWM brightness.
//   Input data is frame-latched, so a digit never changes mid-frame.
//   Sits between user logic (counters, UART/debug regs) and board-level tube pins.
// PARAMETERS
//   DIGITS          4      number of digits scanned, 1..8
//   CLK_DIV         250    I_sys_clk cycles per PWM phase, >=2
//   SEL_ACTIVE_LOW  0      1: O_sel active-low; 0: active-high
//   SEG_ACTIVE_LOW  1      1: segment on = 0 (common anode); 0: segment on = 1
// PORTS
//   I_sys_clk    in   1          system clock, all logic posedge
//   I_rst_n      in   1          synchronous active-low reset
//   I_en         in   1          scan enable; 0 blanks tube and clears scan state
//   I_disp_data  in   4*DIGITS   nibble k shown on digit k (digit 0 = [3:0])
//   I_dp         in   DIGITS     decimal point per digit, 1 = lit
//   I_bright     in   4          brightness: on for I_bright+1 of 16 phases
//   O_sel        out  DIGITS     one-hot digit select (polarity per SEL_ACTIVE_LOW)
//   O_seg        out  8          {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
//   O_frame      out  1          1-cycle pulse when a new frame's data is latched
// BEHAVIOUR
//   Reset (I_rst_n=0 at posedge): all counters 0; shadow regs 0; O_sel all inactive; O_seg all off; O_frame 0.
//   Prescaler div_cnt: 0..CLK_DIV-1 while I_en=1, wraps; ph_tick when div_cnt==CLK_DIV-1.
//   Phase counter ph: 0..15, advances on ph_tick; wrap 15->0 advances digit index dig.
//   Digit index dig: 0..DIGITS-1, wraps to 0; slot length = 16*CLK_DIV cycles; frame = DIGITS slots.
//   Frame latch: on the cycle entering dig=0,ph=0,div_cnt=0 (incl. first cycle after I_en rises):
//     shadow_data<=I_disp_data, shadow_dp<=I_dp, shadow_bright<=I_bright; O_frame=1 that cycle+1.
//   Drive: digit lit iff ph <= shadow_bright; lit -> O_sel one-hot at dig, O_seg = decode(nibble)|dp.
//     Unlit phase -> O_sel all inactive, O_seg all off (no ghosting).
//   Latency: O_sel/O_seg/O_frame registered, one cycle after internal state.
//   Decode: hex 0-F standard glyphs (b,d lower case); dp bit7 independent of nibble.
//   I_bright=15 -> 100% duty; I_bright=0 -> 1/16 duty; change takes effect at next frame only.
//   I_en=0: div_cnt, ph, dig held at 0; O_sel inactive, O_seg off next cycle; shadows keep value.
//   I_en 0->1: scan restarts at digit 0 with a fresh latch and O_frame pulse.
//   Reset mid-frame: immediate return to reset state at next posedge, no partial frame output.
//   DIGITS=1: dig constant 0, frame latch every 16 phases.
// CONFIGURATION
//   Macro DIGITAL_TUBE_LZB_EN (leading-zero blanking):
//     defined: within a latched frame, digits above the highest non-zero nibble are blanked
//       (O_sel inactive for that slot) unless their dp is set; digit 0 always shown.
//     undefined: every digit always shown; no extra logic.
// STRUCTURE
//   Package digital_tube_pkg: SEG7_HEX[16] glyph table (active-high, {g..a}), SEG_OFF,
//     PWM_PHASES=16, function seg7_decode(nibble,dp) -> 8-bit active-high.
//   Sub-module seg7_decoder (combinational, uses pkg); polarity applied at top-level output register.
//   Top: prescaler, phase/digit counters, frame shadow regs, output regs, optional LZB mask.
// TESTING (bench uses CLK_DIV=4, DIGITS=4, SEL_ACTIVE_LOW=0, SEG_ACTIVE_LOW=1)
//   Scan: data=16'h1234, dp=0, bright=15 -> O_sel 0001,0010,0100,1000 each 64 cycles; O_seg F8?->
//     digit0 = 8'b10011001 ('4'), digit3 = 8'b11111001 ('1'); O_frame every 256 cycles.
//   Frame latch: change data to 16'hABCD mid-frame -> old digits complete; new glyphs from next O_frame.
//   PWM: bright=3 -> per 64-cycle slot O_sel active 16 cycles, inactive 48, O_seg=8'hFF when inactive.
//   Enable: drop I_en mid-slot -> next cycle O_sel=0000, O_seg=8'hFF; raise -> digit 0, O_frame pulse.
//   Reset: assert I_rst_n=0 mid-frame -> next posedge O_sel=0000, O_seg=8'hFF, O_frame=0.
//   LZB (macro defined): data=16'h0007, dp=4'b0100 -> digits 3 blank, 2 shows '0.', 1 blank, 0 shows '7'.

Source files
------------

// File: rtl/digital_tube_pkg.sv
// Shared glyph table and decode helper for the multiplexed 7-segment scanner.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied by the top.
package digital_tube_pkg;

   localparam int PWM_PHASES = 16;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // hex 0-F, with lower-case b and d so they differ from 8 and 0
   localparam logic [6:0] SEG7_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [7:0] seg7_decode(input logic [3:0] nibble, input logic dp);
      return {dp, SEG7_HEX[nibble]};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder, active-high {dp,g,f,e,d,c,b,a}.
module seg7_decoder
   import digital_tube_pkg::*;
(
   input  logic [3:0] I_nibble,
   input  logic       I_dp,
   output logic [7:0] O_seg
);

   assign O_seg = seg7_decode(I_nibble, I_dp);

endmodule

// File: rtl/digital_tube_scan.sv
// N-digit multiplexed 7-segment scanner with frame-latched data and 16-level PWM.
// Optional leading-zero blanking is enabled by defining DIGITAL_TUBE_LZB_EN.
module digital_tube_scan
   import digital_tube_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 250,
   parameter bit SEL_ACTIVE_LOW = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  I_sys_clk,
   input  logic                  I_rst_n,
   input  logic                  I_en,
   input  logic [4*DIGITS-1:0]   I_disp_data,
   input  logic [DIGITS-1:0]     I_dp,
   input  logic [3:0]            I_bright,
   output logic [DIGITS-1:0]     O_sel,
   output logic [7:0]            O_seg,
   output logic                  O_frame
);

   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIV_W = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
   localparam logic [3:0]        PH_LAST  = 4'(PWM_PHASES - 1);
   localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{SEL_ACTIVE_LOW}};
   localparam logic [7:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

   logic [DIV_W-1:0]    div_q, div_d;
   logic [3:0]          ph_q, ph_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
   logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [3:0]          shadow_bright_q, shadow_bright_d;
   logic [DIGITS-1:0]   sel_q, sel_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_q, frame_d;

   logic                ph_tick;
   logic                frame_start;
   logic [3:0]          nibble;
   logic                dp_cur;
   logic                digit_shown;
   logic [7:0]          seg_raw;
   logic [DIGITS-1:0]   sel_onehot;

   always_comb begin
      div_d       = '0;
      ph_d        = '0;
      dig_d       = '0;
      ph_tick     = 1'b0;
      frame_start = 1'b0;
      if (I_en) begin
         ph_tick     = (div_q == DIV_LAST);
         frame_start = (div_q == '0) && (ph_q == '0) && (dig_q == '0);
         div_d       = ph_tick ? '0 : div_q + 1'b1;
         ph_d        = ph_tick ? ph_q + 1'b1 : ph_q;
         dig_d       = dig_q;
         if (ph_tick && (ph_q == PH_LAST)) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
         end
      end
   end

   // The output register must show the freshly latched frame on its first cycle,
   // so the drive logic below looks at the shadow next-values.
   always_comb begin
      shadow_data_d   = frame_start ? I_disp_data : shadow_data_q;
      shadow_dp_d     = frame_start ? I_dp        : shadow_dp_q;
      shadow_bright_d = frame_start ? I_bright    : shadow_bright_q;
   end

   always_comb begin
      nibble = 4'h0;
      dp_cur = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig_q == DIG_W'(k)) begin
            nibble = shadow_data_d[4*k +: 4];
            dp_cur = shadow_dp_d[k];
         end
      end
   end

`ifdef DIGITAL_TUBE_LZB_EN
   logic [DIG_W-1:0] hi_idx;

   always_comb begin
      hi_idx = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (shadow_data_d[4*k +: 4] != 4'h0) hi_idx = DIG_W'(k);
      end
      digit_shown = (dig_q <= hi_idx) || dp_cur;
   end
`else
   assign digit_shown = 1'b1;
`endif

   seg7_decoder u_dec (
      .I_nibble (nibble),
      .I_dp     (dp_cur),
      .O_seg    (seg_raw)
   );

   assign sel_onehot = DIGITS'(1) << dig_q;

   always_comb begin
      sel_d   = SEL_IDLE;
      seg_d   = SEG_IDLE;
      frame_d = frame_start;
      if (I_en && digit_shown && (ph_q <= shadow_bright_d)) begin
         sel_d = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
         seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      end
   end

   always_ff @(posedge I_sys_clk) begin
      if (!I_rst_n) begin
         div_q           <= '0;
         ph_q            <= '0;
         dig_q           <= '0;
         shadow_data_q   <= '0;
         shadow_dp_q     <= '0;
         shadow_bright_q <= '0;
         sel_q           <= SEL_IDLE;
         seg_q           <= SEG_IDLE;
         frame_q         <= 1'b0;
      end else begin
         div_q           <= div_d;
         ph_q            <= ph_d;
         dig_q           <= dig_d;
         shadow_data_q   <= shadow_data_d;
         shadow_dp_q     <= shadow_dp_d;
         shadow_bright_q <= shadow_bright_d;
         sel_q           <= sel_d;
         seg_q           <= seg_d;
         frame_q         <= frame_d;
      end
   end

   assign O_sel   = sel_q;
   assign O_seg   = seg_q;
   assign O_frame = frame_q;

endmodule
